// File: rtl/riscv_pkg.sv
// Shared types for the writeback stage: load width codes, FSM states and the
// register-file write payload.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [F3_W-1:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } rf_write_t;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the byte/half/word addressed by the
// offset, sign- or zero-extends it, and flags illegal or misaligned codes.
module load_align
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0]  funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  word,
  output logic [XLEN-1:0]  result,
  output logic             ok
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    result   = '0;
    ok       = 1'b0;
    case (funct3)
      LB: begin
        result = {{24{byte_sel[7]}}, byte_sel};
        ok     = 1'b1;
      end
      LH: begin
        result = {{16{half_sel[15]}}, half_sel};
        ok     = ~offset[0];
      end
      LW: begin
        result = word;
        ok     = (offset == 2'b00);
      end
      LBU: begin
        result = {24'h0, byte_sel};
        ok     = 1'b1;
      end
      LHU: begin
        result = {16'h0, half_sel};
        ok     = ~offset[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage with internal x1..x31 register file and load-wait FSM.
// Define WRITEBACK_FORWARD_EN to add the registered fwd_valid/fwd_rd/fwd_data outputs.
module writeback
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic              wb_valid,
  input  logic              is_load,
  input  logic [F3_W-1:0]   load_funct3,
  input  logic [OFF_W-1:0]  byte_offset,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   pre_wb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              wb_busy,
`ifdef WRITEBACK_FORWARD_EN
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
`endif
  output logic              load_fault
);

  wb_state_e         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [REG_AW-1:0] lat_rd, lat_rd_n;
  logic [F3_W-1:0]   lat_f3, lat_f3_n;
  logic [OFF_W-1:0]  lat_off, lat_off_n;
  logic              fault_n;
  rf_write_t         wr_c;

  logic [F3_W-1:0]   al_f3;
  logic [OFF_W-1:0]  al_off;
  logic [XLEN-1:0]   al_result;
  logic              al_ok;

  logic [XLEN-1:0]   regs [1:31];

  // Legality is judged on live inputs in IDLE; extraction uses latched fields while waiting.
  assign al_f3  = (state == WAIT_LOAD) ? lat_f3  : load_funct3;
  assign al_off = (state == WAIT_LOAD) ? lat_off : byte_offset;

  load_align u_load_align (
    .funct3 (al_f3),
    .offset (al_off),
    .word   (mem_rdata),
    .result (al_result),
    .ok     (al_ok)
  );

  assign cnt_inc = cnt + CNT_W'(1);
  assign wb_busy = (state == WAIT_LOAD);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_rd_n  = lat_rd;
    lat_f3_n  = lat_f3;
    lat_off_n = lat_off;
    fault_n   = 1'b0;
    wr_c      = '0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          if (!is_load) begin
            wr_c.en   = 1'b1;
            wr_c.addr = rd;
            wr_c.data = pre_wb;
          end else if (al_ok) begin
            state_n   = WAIT_LOAD;
            cnt_n     = '0;
            lat_rd_n  = rd;
            lat_f3_n  = load_funct3;
            lat_off_n = byte_offset;
          end else begin
            fault_n = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        // mem_valid takes priority over a timeout landing on the same cycle
        if (mem_valid) begin
          wr_c.en   = 1'b1;
          wr_c.addr = lat_rd;
          wr_c.data = al_result;
          state_n   = IDLE;
        end else if (cnt_inc == CNT_W'(LOAD_TIMEOUT)) begin
          fault_n = 1'b1;
          state_n = IDLE;
          cnt_n   = cnt_inc;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    wr_c.en = wr_c.en & clk_enable & (wr_c.addr != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_rd     <= '0;
      lat_f3     <= '0;
      lat_off    <= '0;
      load_fault <= 1'b0;
    end else if (clk_enable) begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat_rd     <= lat_rd_n;
      lat_f3     <= lat_f3_n;
      lat_off    <= lat_off_n;
      load_fault <= fault_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wr_c.en) begin
      regs[wr_c.addr] <= wr_c.data;
    end
  end

  // Read ports bypass the pending write so a same-cycle reader sees the new value.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0)
      rs1_data = (wr_c.en && wr_c.addr == rs1_addr) ? wr_c.data : regs[rs1_addr];
    if (rs2_addr != '0)
      rs2_data = (wr_c.en && wr_c.addr == rs2_addr) ? wr_c.data : regs[rs2_addr];
  end

`ifdef WRITEBACK_FORWARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else if (clk_enable) begin
      fwd_valid <= wr_c.en;
      if (wr_c.en) begin
        fwd_rd   <= wr_c.addr;
        fwd_data <= wr_c.data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized loads
// and ALU writes against a register-file / load-extraction reference model.
module tb_writeback;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enable = 1'b1;
  logic        wb_valid = 1'b0;
  logic        is_load = 1'b0;
  logic [2:0]  load_funct3 = '0;
  logic [1:0]  byte_offset = '0;
  logic [4:0]  rd = '0;
  logic [31:0] pre_wb = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_busy, load_fault;
`ifdef WRITEBACK_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rf [32];

  writeback #(.LOAD_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_enable  (clk_enable),
    .wb_valid    (wb_valid),
    .is_load     (is_load),
    .load_funct3 (load_funct3),
    .byte_offset (byte_offset),
    .rd          (rd),
    .pre_wb      (pre_wb),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_busy     (wb_busy),
`ifdef WRITEBACK_FORWARD_EN
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
`endif
    .load_fault  (load_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result from the architectural rules: {legal, value}.
  function automatic logic [32:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] b, h, v;
    logic ok;
    b  = (w >> (8 * off)) & 32'hFF;
    h  = (w >> (16 * (off / 2))) & 32'hFFFF;
    v  = '0;
    ok = 1'b0;
    case (f3)
      3'd0: begin ok = 1'b1;            v = (b >= 32'd128)   ? b - 32'd256   : b; end
      3'd1: begin ok = (off % 2 == 0);  v = (h >= 32'd32768) ? h - 32'd65536 : h; end
      3'd2: begin ok = (off == 0);      v = w; end
      3'd4: begin ok = 1'b1;            v = b; end
      3'd5: begin ok = (off % 2 == 0);  v = h; end
      default: ok = 1'b0;
    endcase
    return {ok, v};
  endfunction

  task automatic drive_alu(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1; is_load = 1'b0; rd = r; pre_wb = v;
    tick();
    wb_valid = 1'b0;
    if (r != 0) model_rf[r] = v;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] r);
    wb_valid = 1'b1; is_load = 1'b1; load_funct3 = f3; byte_offset = off; rd = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (wb_busy !== 1'b0 || load_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy=%b fault=%b required 0/0", wb_busy, load_fault);
    end
`ifdef WRITEBACK_FORWARD_EN
    n_checks++;
    if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fwd: v=%b rd=%0d d=%h required zeros", fwd_valid, fwd_rd, fwd_data);
    end
`endif
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = '0;
      rs1_addr = 5'(r);
      #1;
      n_checks++;
      if (rs1_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg x%0d: got %h required 0", r, rs1_data);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_write();
    logic [4:0]  r, q;
    logic [31:0] v;
    wb_valid = 1'b1; is_load = 1'b0; rd = 5'd5; pre_wb = 32'hDEADBEEF; rs1_addr = 5'd5;
    #1;
    n_checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_through x5: got %h required deadbeef", rs1_data);
    end
    tick();
    wb_valid = 1'b0;
    model_rf[5] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (rs1_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL alu_read x5: got %h required deadbeef", rs1_data);
    end
    for (int i = 0; i < 24; i++) begin
      r = 5'($urandom_range(0, 31));
      v = $urandom;
      wb_valid = 1'b1; is_load = 1'b0; rd = r; pre_wb = v; rs1_addr = r;
      #1;
      n_checks++;
      if (rs1_data !== ((r == 0) ? 32'd0 : v)) begin
        n_fail++;
        $display("FAIL rand_wt x%0d: got %h required %h", r, rs1_data, (r == 0) ? 32'd0 : v);
      end
      tick();
      wb_valid = 1'b0;
      if (r != 0) model_rf[r] = v;
      q = 5'($urandom_range(0, 31));
      rs2_addr = q;
      #1;
      n_checks++;
      if (rs2_data !== model_rf[q]) begin
        n_fail++;
        $display("FAIL rand_read x%0d: got %h required %h", q, rs2_data, model_rf[q]);
      end
    end
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; is_load = 1'b0; rd = 5'd0; pre_wb = 32'h1; rs1_addr = 5'd0;
    #1;
    n_checks++;
    if (rs1_data !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_wt: got %h required 0", rs1_data);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    n_checks++;
    if (rs1_data !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_read: got %h required 0", rs1_data);
    end
  endtask

  task automatic test_lb_busy();
    int busy_cycles = 0;
    drive_load(3'b000, 2'd2, 5'd7);
    tick();
    wb_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!wb_busy) break;
      busy_cycles++;
      if (busy_cycles == 3) begin
        mem_valid = 1'b1; mem_rdata = 32'h12F45678; rs1_addr = 5'd7;
        #1;
        n_checks++;
        if (rs1_data !== 32'hFFFFFFF4) begin
          n_fail++;
          $display("FAIL lb_wt x7: got %h required fffffff4", rs1_data);
        end
      end
      tick();
      mem_valid = 1'b0;
    end
    model_rf[7] = 32'hFFFFFFF4;
    n_checks++;
    if (busy_cycles != 3) begin
      n_fail++;
      $display("FAIL lb_busy_cycles: got %0d required 3", busy_cycles);
    end
    rs1_addr = 5'd7;
    #1;
    n_checks++;
    if (rs1_data !== 32'hFFFFFFF4 || load_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_result x7: got %h fault=%b required fffffff4 fault=0", rs1_data, load_fault);
    end
  endtask

  task automatic test_half_loads();
    drive_load(3'b101, 2'd2, 5'd12);
    tick();
    wb_valid = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h8001FFFF;
    tick();
    mem_valid = 1'b0;
    model_rf[12] = 32'h00008001;
    rs2_addr = 5'd12;
    #1;
    n_checks++;
    if (rs2_data !== 32'h00008001 || wb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu x12: got %h busy=%b required 00008001 busy=0", rs2_data, wb_busy);
    end
    drive_load(3'b001, 2'd1, 5'd12);
    tick();
    wb_valid = 1'b0;
    n_checks++;
    if (load_fault !== 1'b1 || wb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_misaligned: fault=%b busy=%b required 1/0", load_fault, wb_busy);
    end
    tick();
    n_checks++;
    if (load_fault !== 1'b0 || rs2_data !== 32'h00008001) begin
      n_fail++;
      $display("FAIL lh_nowrite: fault=%b x12=%h required 0/00008001", load_fault, rs2_data);
    end
  endtask

  task automatic test_timeout();
    drive_alu(5'd9, 32'h000055AA);
    drive_load(3'b010, 2'd0, 5'd9);
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      n_checks++;
      if (wb_busy !== 1'b1 || load_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: busy=%b fault=%b required 1/0", i, wb_busy, load_fault);
      end
      tick();
    end
    n_checks++;
    if (wb_busy !== 1'b0 || load_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fault: busy=%b fault=%b required 0/1", wb_busy, load_fault);
    end
    mem_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_valid = 1'b0;
    rs1_addr = 5'd9;
    #1;
    n_checks++;
    if (load_fault !== 1'b0 || wb_busy !== 1'b0 || rs1_data !== 32'h000055AA) begin
      n_fail++;
      $display("FAIL late_mem_valid: fault=%b busy=%b x9=%h required 0/0/000055aa",
               load_fault, wb_busy, rs1_data);
    end
  endtask

  task automatic test_stall();
    drive_alu(5'd10, 32'h01020304);
    drive_load(3'b010, 2'd0, 5'd10);
    tick();
    wb_valid = 1'b0; clk_enable = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) tick();
    rs1_addr = 5'd10;
    #1;
    n_checks++;
    if (wb_busy !== 1'b1 || load_fault !== 1'b0 || rs1_data !== 32'h01020304) begin
      n_fail++;
      $display("FAIL stall_hold: busy=%b fault=%b x10=%h required 1/0/01020304",
               wb_busy, load_fault, rs1_data);
    end
    clk_enable = 1'b1; mem_valid = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      n_checks++;
      if (wb_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_count%0d: busy=%b required 1", i, wb_busy);
      end
    end
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    model_rf[10] = 32'hCAFEF00D;
    #1;
    n_checks++;
    if (wb_busy !== 1'b0 || load_fault !== 1'b0 || rs1_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL edge_mem_wins: busy=%b fault=%b x10=%h required 0/0/cafef00d",
               wb_busy, load_fault, rs1_data);
    end
  endtask

  task automatic test_random_loads();
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  r;
    logic [31:0] w;
    logic [32:0] m;
    int          d;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      r = 5'($urandom_range(0, 31));
      w = $urandom;
      d = $urandom_range(0, TO - 1);
      m = model_load(f3, off, w);
      drive_load(f3, off, r);
      tick();
      wb_valid = 1'b0;
      if (!m[32]) begin
        n_checks++;
        if (load_fault !== 1'b1 || wb_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_illegal f3=%0d off=%0d: fault=%b busy=%b required 1/0",
                   f3, off, load_fault, wb_busy);
        end
        tick();
      end else begin
        n_checks++;
        if (wb_busy !== 1'b1 || load_fault !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_accept f3=%0d off=%0d: busy=%b fault=%b required 1/0",
                   f3, off, wb_busy, load_fault);
        end
        // upstream noise while waiting must be ignored
        wb_valid = 1'b1; is_load = 1'b0; rd = 5'($urandom_range(1, 31)); pre_wb = $urandom;
        for (int k = 0; k < d; k++) begin
          mem_rdata = $urandom;
          tick();
        end
        mem_valid = 1'b1; mem_rdata = w;
        tick();
        mem_valid = 1'b0; wb_valid = 1'b0;
        if (r != 0) model_rf[r] = m[31:0];
      end
      rs2_addr = r;
      #1;
      n_checks++;
      if (rs2_data !== model_rf[r] || wb_busy !== 1'b0 || load_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_load f3=%0d off=%0d d=%0d x%0d: got %h busy=%b fault=%b required %h/0/0",
                 f3, off, d, r, rs2_data, wb_busy, load_fault, model_rf[r]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    drive_alu(5'd11, 32'h11111111);
    drive_load(3'b010, 2'd0, 5'd11);
    tick();
    wb_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (wb_busy !== 1'b0 || load_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_load: busy=%b fault=%b required 0/0", wb_busy, load_fault);
    end
    mem_valid = 1'b1; mem_rdata = 32'hBADBAD00;
    tick();
    rst = 1'b0; mem_valid = 1'b0;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      #1;
      n_checks++;
      if (rs1_data !== 32'd0) begin
        n_fail++;
        $display("FAIL rst_clear x%0d: got %h required 0", r, rs1_data);
      end
    end
    tick();
    n_checks++;
    if (wb_busy !== 1'b0 || load_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: busy=%b fault=%b required 0/0", wb_busy, load_fault);
    end
  endtask

`ifdef WRITEBACK_FORWARD_EN
  task automatic test_forward();
    drive_alu(5'd3, 32'h000000A5);
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL fwd_x3: v=%b rd=%0d d=%h required 1/3/000000a5", fwd_valid, fwd_rd, fwd_data);
    end
    drive_alu(5'd0, 32'h1);
    n_checks++;
    if (fwd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_x0: v=%b required 0", fwd_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_write();
    test_x0();
    test_lb_busy();
    test_half_loads();
    test_timeout();
    test_stall();
    test_random_loads();
    test_reset_mid_load();
`ifdef WRITEBACK_FORWARD_EN
    test_forward();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 15: WAIT_LOAD cycles (with clk_enable high) before a load is abandoned; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clk_enable  input  1  global stall; low = all state holds.
REQ-005 wb_valid  input  1  instruction present from the pre-writeback stage.
REQ-006 is_load  input  1  instruction is a load; result comes from memory, not pre_wb.
REQ-007 load_funct3  input  3  RV32I load width/sign code.
REQ-008 byte_offset  input  2  low two bits of the load address.
REQ-009 rd  input  5  destination register.
REQ-010 pre_wb  input  32  non-load result from the pre-writeback stage.
REQ-011 mem_rdata  input  32  aligned memory word.
REQ-012 mem_valid  input  1  mem_rdata valid this cycle.
REQ-013 rs1_addr, rs2_addr  input  5 each  read-port addresses.
REQ-014 rs1_data, rs2_data  output  32 each  read-port data.
REQ-015 wb_busy  output  1  stage waiting on memory; upstream must hold.
REQ-016 load_fault  output  1  one-cycle pulse: illegal, misaligned or timed-out load.

Function
REQ-017 Writes and state changes SHALL occur only on posedge clk with clk_enable high; the timeout counter SHALL also hold while clk_enable is low.
REQ-018 FSM states SHALL be IDLE and WAIT_LOAD; wb_busy SHALL be 1 exactly when state is WAIT_LOAD.
REQ-019 IDLE, wb_valid=1, is_load=0: pre_wb SHALL be written to rd at that edge; state stays IDLE.
REQ-020 IDLE, wb_valid=1, is_load=1, legal and aligned: no write; go to WAIT_LOAD; clear the counter and latch rd, funct3 and offset.
REQ-021 Legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other code SHALL pulse load_fault on the next cycle, write nothing and stay IDLE.
REQ-022 Misaligned loads (LH/LHU with odd offset; LW with nonzero offset) SHALL be handled the same way as illegal funct3.
REQ-023 WAIT_LOAD with mem_valid=1: the extracted, extended value SHALL be written to the latched rd; return to IDLE.
REQ-024 Extraction: byte = mem_rdata[8*off+7:8*off]; half = mem_rdata[16*off[1]+15:16*off[1]]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-025 WAIT_LOAD without mem_valid: the counter SHALL increment. On reaching LOAD_TIMEOUT it SHALL pulse load_fault, write nothing and return to IDLE.
REQ-026 If mem_valid arrives in the same cycle the counter reaches LOAD_TIMEOUT, mem_valid wins: the write completes and there is no fault.
REQ-027 mem_valid in IDLE SHALL be ignored; wb_valid in WAIT_LOAD SHALL be ignored.
REQ-028 Writes to x0 SHALL be discarded; reads of x0 SHALL return 0.
REQ-029 Read ports SHALL be combinational with write-through: a read matching the address being written this cycle returns the new value.
REQ-030 A register file of 31 x 32-bit entries (x1..x31) SHALL be internal to this block.

Reset
REQ-031 While rst is high: x1..x31 = 0, state = IDLE, counter = 0, latched fields = 0, wb_busy = 0, load_fault = 0, fwd_* = 0.
REQ-032 A rst assertion during WAIT_LOAD SHALL abandon the load with no write and no fault pulse.

Configuration
REQ-033 Macro WRITEBACK_FORWARD_EN SHALL control the forwarding outputs.
REQ-034 Defined: the block SHALL add outputs fwd_valid (1 bit), fwd_rd (5 bits) and fwd_data (32 bits), registered, mirroring each committed non-x0 write one cycle after it.
REQ-035 Undefined: those ports SHALL be absent and no forwarding logic shall be present.

Structure
REQ-036 Package riscv_pkg SHALL hold the load_funct3 enum (LB/LH/LW/LBU/LHU) and the wb_state_e enum (IDLE/WAIT_LOAD).
REQ-037 A combinational sub-module load_align SHALL take funct3, offset and the word, and return the 32-bit result plus a legal/aligned flag.

Verification
REQ-038 Reset, then x5 <- pre_wb 0xDEADBEEF (non-load) -> rs1_addr=5 reads 0xDEADBEEF the next cycle; reading in the same cycle returns it via write-through.
REQ-039 LB with offset 2, then mem_valid with mem_rdata 0x12F45678 three cycles later -> x7 = 0xFFFFFFF4; wb_busy high for exactly 3 cycles.
REQ-040 LHU with offset 2, mem_rdata 0x8001FFFF -> rd = 0x00008001. LH with offset 1 -> load_fault pulse and no write.
REQ-041 LW with no mem_valid and LOAD_TIMEOUT=4 -> load_fault after 4 WAIT cycles, then IDLE; a later mem_valid is ignored.
REQ-042 Write to x0 with pre_wb 0x1 -> x0 still reads 0. clk_enable low for 5 cycles in WAIT_LOAD -> no timeout advance.
REQ-043 rst asserted mid-WAIT_LOAD -> IDLE and registers 0, no fault. With WRITEBACK_FORWARD_EN: write x3=0xA5 -> fwd_valid=1, fwd_rd=3, fwd_data=0xA5 one cycle later.
